// File: rtl/sata_fis_arbiter.sv
// Two-requester FIS stream arbiter for the SATA transport layer.
// Requesters are served round-robin at frame granularity: once a multi-dword
// frame starts, the grant is held until that requester presents eop. Frames
// longer than MAXLEN dwords are cut short with eop+err on the MAXLEN-th dword
// and the remainder of the frame is silently drained from the requester.
module sata_fis_arbiter #(
    parameter int MAXLEN = 2049
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i1_dat,
    input  logic        i1_val,
    input  logic        i1_eop,
    input  logic        i1_err,
    output logic        i1_rdy,
    input  logic [31:0] i2_dat,
    input  logic        i2_val,
    input  logic        i2_eop,
    input  logic        i2_err,
    output logic        i2_rdy,
    output logic [31:0] o_dat,
    output logic        o_val,
    output logic        o_eop,
    output logic        o_err,
    input  logic        o_rdy,
    output logic        owner,
    output logic        busy,
    output logic        trunc
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GRANT1 = 3'd1,
        GRANT2 = 3'd2,
        DRAIN1 = 3'd3,
        DRAIN2 = 3'd4
    } state_t;

    // Counter value seen while the MAXLEN-th dword is on the bus.
    localparam logic [11:0] LAST_CNT = 12'(MAXLEN - 1);

    state_t      state_r;
    logic [11:0] cnt_r;
    logic        last_r;
    logic        busy_r;
    logic        trunc_r;

    logic        sel_s;
    logic [31:0] sel_dat_s;
    logic        sel_val_s;
    logic        sel_eop_s;
    logic        sel_err_s;
    logic        sel_rdy_s;
    logic        grant_s;
    logic        drain_s;
    logic        last_word_s;
    logic        xfer_s;

    // Requester selection: zero-latency round-robin in IDLE, locked otherwise.
    always_comb begin
        sel_s = ~last_r;
        case (state_r)
            IDLE: begin
                if (i1_val != i2_val) begin
                    sel_s = i2_val;
                end else begin
                    sel_s = ~last_r;
                end
            end
            GRANT1, DRAIN1: sel_s = 1'b0;
            GRANT2, DRAIN2: sel_s = 1'b1;
            default:        sel_s = ~last_r;
        endcase
    end

    // Multiplex the selected requester's stream and derive the handshake.
    always_comb begin
        if (sel_s) begin
            sel_dat_s = i2_dat;
            sel_val_s = i2_val;
            sel_eop_s = i2_eop;
            sel_err_s = i2_err;
        end else begin
            sel_dat_s = i1_dat;
            sel_val_s = i1_val;
            sel_eop_s = i1_eop;
            sel_err_s = i1_err;
        end
        grant_s     = (state_r == GRANT1) || (state_r == GRANT2);
        drain_s     = (state_r == DRAIN1) || (state_r == DRAIN2);
        // The forced eop/err is shown as soon as the word is presented so
        // that o_eop stays stable while downstream back-pressures.
        last_word_s = grant_s && (cnt_r == LAST_CNT) && !sel_eop_s;
        if (drain_s) begin
            sel_rdy_s = 1'b1;
        end else begin
            sel_rdy_s = o_rdy;
        end
        xfer_s = sel_val_s && sel_rdy_s;
    end

    // Drive the shared output stream and the per-requester ready lines.
    always_comb begin
        o_dat = sel_dat_s;
        if (drain_s) begin
            o_val = 1'b0;
            o_eop = 1'b0;
            o_err = 1'b0;
        end else begin
            o_val = sel_val_s;
            o_eop = sel_val_s && (sel_eop_s || last_word_s);
            o_err = sel_val_s && (sel_err_s || last_word_s);
        end
        i1_rdy = !sel_s && sel_rdy_s;
        i2_rdy = sel_s && sel_rdy_s;
        owner  = sel_s;
        busy   = busy_r;
        trunc  = trunc_r;
    end

    // Frame-level state machine: grant tracking, dword count, truncation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 12'd0;
            last_r  <= 1'b1;
            busy_r  <= 1'b0;
            trunc_r <= 1'b0;
        end else begin
            trunc_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (xfer_s) begin
                        last_r <= sel_s;
                        if (!sel_eop_s) begin
                            state_r <= sel_s ? GRANT2 : GRANT1;
                            cnt_r   <= 12'd1;
                            busy_r  <= 1'b1;
                        end
                    end
                end
                GRANT1, GRANT2: begin
                    if (xfer_s) begin
                        if (sel_eop_s) begin
                            state_r <= IDLE;
                            cnt_r   <= 12'd0;
                            busy_r  <= 1'b0;
                        end else if (last_word_s) begin
                            state_r <= sel_s ? DRAIN2 : DRAIN1;
                            cnt_r   <= cnt_r + 12'd1;
                            trunc_r <= 1'b1;
                        end else begin
                            cnt_r   <= cnt_r + 12'd1;
                        end
                    end
                end
                DRAIN1, DRAIN2: begin
                    if (xfer_s && sel_eop_s) begin
                        state_r <= IDLE;
                        cnt_r   <= 12'd0;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 12'd0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sata_fis_arbiter.sv
// Self-checking bench for sata_fis_arbiter: a default-MAXLEN instance and a
// MAXLEN=4 instance share the same stimulus; a scoreboard queue holds the
// expected output words for the instance under test.
module tb_sata_fis_arbiter;

    typedef struct {
        logic [31:0] dat;
        logic        eop;
        logic        err;
    } word_t;

    typedef struct {
        logic [31:0] dat;
        logic        eop;
        logic        err;
        logic        owner;
        logic        busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i1_dat, i2_dat;
    logic        i1_val, i1_eop, i1_err;
    logic        i2_val, i2_eop, i2_err;
    logic        o_rdy;

    logic [31:0] a_o_dat, b_o_dat;
    logic        a_i1_rdy, a_i2_rdy, a_o_val, a_o_eop, a_o_err, a_owner, a_busy, a_trunc;
    logic        b_i1_rdy, b_i2_rdy, b_o_val, b_o_eop, b_o_err, b_owner, b_busy, b_trunc;

    word_t src1[$];
    word_t src2[$];
    exp_t  exp_q[$];
    word_t dump;
    exp_t  e;

    logic        en1, en2, use_b;
    logic [31:0] ob_dat;
    logic        ob_val, ob_eop, ob_err, ob_owner, ob_busy, ob_trunc, ob_rdy1, ob_rdy2;
    logic        ob_xfer, hs1, hs2;

    int checks   = 0;
    int failures = 0;

    sata_fis_arbiter dut_a (
        .clk(clk), .reset(reset),
        .i1_dat(i1_dat), .i1_val(i1_val), .i1_eop(i1_eop), .i1_err(i1_err), .i1_rdy(a_i1_rdy),
        .i2_dat(i2_dat), .i2_val(i2_val), .i2_eop(i2_eop), .i2_err(i2_err), .i2_rdy(a_i2_rdy),
        .o_dat(a_o_dat), .o_val(a_o_val), .o_eop(a_o_eop), .o_err(a_o_err), .o_rdy(o_rdy),
        .owner(a_owner), .busy(a_busy), .trunc(a_trunc)
    );

    sata_fis_arbiter #(.MAXLEN(4)) dut_b (
        .clk(clk), .reset(reset),
        .i1_dat(i1_dat), .i1_val(i1_val), .i1_eop(i1_eop), .i1_err(i1_err), .i1_rdy(b_i1_rdy),
        .i2_dat(i2_dat), .i2_val(i2_val), .i2_eop(i2_eop), .i2_err(i2_err), .i2_rdy(b_i2_rdy),
        .o_dat(b_o_dat), .o_val(b_o_val), .o_eop(b_o_eop), .o_err(b_o_err), .o_rdy(o_rdy),
        .owner(b_owner), .busy(b_busy), .trunc(b_trunc)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic push1(input logic [31:0] d, input logic eop, input logic err);
        word_t w;
        w.dat = d; w.eop = eop; w.err = err;
        src1.push_back(w);
    endtask

    task automatic push2(input logic [31:0] d, input logic eop, input logic err);
        word_t w;
        w.dat = d; w.eop = eop; w.err = err;
        src2.push_back(w);
    endtask

    task automatic expect_word(input logic [31:0] d, input logic eop, input logic err,
                               input logic own, input logic bsy);
        exp_t x;
        x.dat = d; x.eop = eop; x.err = err; x.owner = own; x.busy = bsy;
        exp_q.push_back(x);
    endtask

    // One clock: drive requesters from their queues, sample at negedge,
    // retire source words that handshook at the following posedge.
    task automatic step();
        i1_val = en1 && (src1.size() > 0);
        i1_dat = i1_val ? src1[0].dat : 32'h0;
        i1_eop = i1_val ? src1[0].eop : 1'b0;
        i1_err = i1_val ? src1[0].err : 1'b0;
        i2_val = en2 && (src2.size() > 0);
        i2_dat = i2_val ? src2[0].dat : 32'h0;
        i2_eop = i2_val ? src2[0].eop : 1'b0;
        i2_err = i2_val ? src2[0].err : 1'b0;
        @(negedge clk);
        if (use_b) begin
            ob_dat = b_o_dat; ob_val = b_o_val; ob_eop = b_o_eop; ob_err = b_o_err;
            ob_owner = b_owner; ob_busy = b_busy; ob_trunc = b_trunc;
            ob_rdy1 = b_i1_rdy; ob_rdy2 = b_i2_rdy;
        end else begin
            ob_dat = a_o_dat; ob_val = a_o_val; ob_eop = a_o_eop; ob_err = a_o_err;
            ob_owner = a_owner; ob_busy = a_busy; ob_trunc = a_trunc;
            ob_rdy1 = a_i1_rdy; ob_rdy2 = a_i2_rdy;
        end
        hs1     = i1_val && ob_rdy1;
        hs2     = i2_val && ob_rdy2;
        ob_xfer = ob_val && o_rdy;
        @(posedge clk);
        #1;
        if (hs1) dump = src1.pop_front();
        if (hs2) dump = src2.pop_front();
    endtask

    task automatic clear_all();
        src1.delete();
        src2.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        use_b = 1'b0; en1 = 1'b0; en2 = 1'b1; o_rdy = 1'b1; reset = 1'b1;
        push2(32'h5A5A_0001, 1'b1, 1'b0);
        step();
        checks++;
        if (ob_busy !== 1'b0 || ob_trunc !== 1'b0) begin
            failures++;
            $display("FAIL reset_regs busy=%b trunc=%b required 0 0", ob_busy, ob_trunc);
        end
        checks++;
        if (ob_owner !== 1'b1 || ob_rdy2 !== 1'b1 || ob_rdy1 !== 1'b0 || ob_val !== 1'b1 || ob_dat !== 32'h5A5A_0001) begin
            failures++;
            $display("FAIL reset_idle_pass owner=%b rdy2=%b rdy1=%b val=%b dat=%h required 1 1 0 1 5a5a0001",
                     ob_owner, ob_rdy2, ob_rdy1, ob_val, ob_dat);
        end
        clear_all();
        step();
        checks++;
        if (ob_owner !== 1'b0 || ob_val !== 1'b0 || ob_eop !== 1'b0 || ob_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_novalid owner=%b val=%b eop=%b err=%b required 0 0 0 0",
                     ob_owner, ob_val, ob_eop, ob_err);
        end
        reset = 1'b0;
        en1 = 1'b1;
    endtask

    task automatic test_basic();
        push1(32'hA000_0001, 1'b0, 1'b0);
        push1(32'hA000_0002, 1'b0, 1'b0);
        push1(32'hA000_0003, 1'b1, 1'b0);
        push2(32'hB000_0001, 1'b0, 1'b0);
        push2(32'hB000_0002, 1'b1, 1'b0);
        expect_word(32'hA000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_word(32'hA000_0002, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_word(32'hA000_0003, 1'b1, 1'b0, 1'b0, 1'b1);
        expect_word(32'hB000_0001, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_word(32'hB000_0002, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
            step();
            if (ob_val && !ob_owner) begin
                checks++;
                if (ob_rdy2 !== 1'b0) begin
                    failures++;
                    $display("FAIL basic_i2_rdy got %b required 0 during frame of #1", ob_rdy2);
                end
            end
            if (ob_xfer) begin
                e = exp_q.pop_front();
                checks++;
                if (ob_dat !== e.dat || ob_eop !== e.eop || ob_err !== e.err || ob_owner !== e.owner || ob_busy !== e.busy) begin
                    failures++;
                    $display("FAIL basic_word got dat=%h eop=%b err=%b owner=%b busy=%b required %h %b %b %b %b",
                             ob_dat, ob_eop, ob_err, ob_owner, ob_busy, e.dat, e.eop, e.err, e.owner, e.busy);
                end
            end
        end
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL basic_timeout pending=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_alternate();
        for (int k = 0; k < 4; k++) begin
            push1(32'hC100_0000 + 32'(k), 1'b1, 1'b0);
            push2(32'hC200_0000 + 32'(k), 1'b1, 1'b0);
            expect_word(32'hC100_0000 + 32'(k), 1'b1, 1'b0, 1'b0, 1'b0);
            expect_word(32'hC200_0000 + 32'(k), 1'b1, 1'b0, 1'b1, 1'b0);
        end
        for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
            step();
            checks++;
            if (ob_xfer !== 1'b1) begin
                failures++;
                $display("FAIL alt_bubble cycle=%0d xfer=%b required 1", c, ob_xfer);
            end
            if (ob_xfer) begin
                e = exp_q.pop_front();
                checks++;
                if (ob_dat !== e.dat || ob_eop !== e.eop || ob_owner !== e.owner || ob_busy !== e.busy) begin
                    failures++;
                    $display("FAIL alt_word got dat=%h eop=%b owner=%b busy=%b required %h %b %b %b",
                             ob_dat, ob_eop, ob_owner, ob_busy, e.dat, e.eop, e.owner, e.busy);
                end
            end
        end
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL alt_timeout pending=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_rdy_toggle();
        for (int k = 0; k < 4; k++) begin
            push2(32'hD000_0000 + 32'(k), (k == 3), 1'b0);
            expect_word(32'hD000_0000 + 32'(k), (k == 3), 1'b0, 1'b1, (k != 0));
        end
        for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
            o_rdy = (c % 2 == 0);
            step();
            checks++;
            if (ob_rdy2 !== o_rdy || ob_rdy1 !== 1'b0 || ob_owner !== 1'b1) begin
                failures++;
                $display("FAIL toggle_ctl rdy2=%b rdy1=%b owner=%b required %b 0 1",
                         ob_rdy2, ob_rdy1, ob_owner, o_rdy);
            end
            if (ob_xfer) begin
                e = exp_q.pop_front();
                checks++;
                if (ob_dat !== e.dat || ob_eop !== e.eop || ob_busy !== e.busy) begin
                    failures++;
                    $display("FAIL toggle_word got dat=%h eop=%b busy=%b required %h %b %b",
                             ob_dat, ob_eop, ob_busy, e.dat, e.eop, e.busy);
                end
            end
        end
        o_rdy = 1'b1;
        checks++;
        if (exp_q.size() !== 0 || src2.size() !== 0) begin
            failures++;
            $display("FAIL toggle_count pending=%0d src_left=%0d required 0 0", exp_q.size(), src2.size());
        end
    endtask

    task automatic test_stall();
        push1(32'hE100_0001, 1'b0, 1'b0);
        push1(32'hE100_0002, 1'b0, 1'b1);
        push1(32'hE100_0003, 1'b1, 1'b0);
        push2(32'hE200_0001, 1'b1, 1'b0);
        expect_word(32'hE100_0001, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_word(32'hE100_0002, 1'b0, 1'b1, 1'b0, 1'b1);
        expect_word(32'hE100_0003, 1'b1, 1'b0, 1'b0, 1'b1);
        expect_word(32'hE200_0001, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
            en1 = !(c == 1 || c == 2);
            step();
            if (c == 1 || c == 2) begin
                checks++;
                if (ob_val !== 1'b0 || ob_eop !== 1'b0 || ob_err !== 1'b0 || ob_owner !== 1'b0 ||
                    ob_rdy2 !== 1'b0 || ob_busy !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_hold val=%b eop=%b err=%b owner=%b rdy2=%b busy=%b required 0 0 0 0 0 1",
                             ob_val, ob_eop, ob_err, ob_owner, ob_rdy2, ob_busy);
                end
            end
            if (ob_xfer) begin
                e = exp_q.pop_front();
                checks++;
                if (ob_dat !== e.dat || ob_eop !== e.eop || ob_err !== e.err || ob_owner !== e.owner || ob_busy !== e.busy) begin
                    failures++;
                    $display("FAIL stall_word got dat=%h eop=%b err=%b owner=%b busy=%b required %h %b %b %b %b",
                             ob_dat, ob_eop, ob_err, ob_owner, ob_busy, e.dat, e.eop, e.err, e.owner, e.busy);
                end
            end
        end
        en1 = 1'b1;
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL stall_timeout pending=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_maxlen(input int nwords, input int exp_trunc);
        int tcount;
        int nout;
        tcount = 0;
        nout   = (nwords > 4) ? 4 : nwords;
        use_b  = 1'b1;
        for (int k = 0; k < nwords; k++) begin
            push1(32'hF000_0000 + 32'(k), (k == nwords - 1), 1'b0);
        end
        for (int k = 0; k < nout; k++) begin
            expect_word(32'hF000_0000 + 32'(k), (k == nout - 1), (nwords > 4) && (k == 3), 1'b0, (k != 0));
        end
        for (int c = 0; c < 30 && (src1.size() > 0 || exp_q.size() > 0); c++) begin
            step();
            if (ob_trunc) tcount++;
            if (exp_q.size() == 0) begin
                checks++;
                if (ob_val !== 1'b0) begin
                    failures++;
                    $display("FAIL maxlen_drain_val len=%0d val=%b required 0", nwords, ob_val);
                end
            end else if (ob_xfer) begin
                e = exp_q.pop_front();
                checks++;
                if (ob_dat !== e.dat || ob_eop !== e.eop || ob_err !== e.err || ob_owner !== e.owner || ob_busy !== e.busy) begin
                    failures++;
                    $display("FAIL maxlen_word len=%0d got dat=%h eop=%b err=%b owner=%b busy=%b required %h %b %b %b %b",
                             nwords, ob_dat, ob_eop, ob_err, ob_owner, ob_busy, e.dat, e.eop, e.err, e.owner, e.busy);
                end
            end
        end
        for (int c = 0; c < 2; c++) begin
            step();
            if (ob_trunc) tcount++;
        end
        checks++;
        if (tcount !== exp_trunc) begin
            failures++;
            $display("FAIL maxlen_trunc len=%0d pulses=%0d required %0d", nwords, tcount, exp_trunc);
        end
        checks++;
        if (ob_busy !== 1'b0 || src1.size() !== 0 || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL maxlen_end len=%0d busy=%b src_left=%0d pending=%0d required 0 0 0",
                     nwords, ob_busy, src1.size(), exp_q.size());
        end
        use_b = 1'b0;
    endtask

    task automatic test_reset_mid();
        use_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push2(32'h9000_0000 + 32'(k), (k == 3), 1'b0);
        end
        expect_word(32'h9000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_word(32'h9000_0001, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int c = 0; c < 2; c++) begin
            step();
            if (ob_xfer) begin
                e = exp_q.pop_front();
                checks++;
                if (ob_dat !== e.dat || ob_owner !== e.owner || ob_busy !== e.busy) begin
                    failures++;
                    $display("FAIL rstmid_word got dat=%h owner=%b busy=%b required %h %b %b",
                             ob_dat, ob_owner, ob_busy, e.dat, e.owner, e.busy);
                end
            end
        end
        reset = 1'b1;
        #1;
        checks++;
        if (a_busy !== 1'b0 || a_trunc !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_regs busy=%b trunc=%b required 0 0", a_busy, a_trunc);
        end
        clear_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
        push1(32'h9100_0001, 1'b1, 1'b0);
        push2(32'h9200_0001, 1'b1, 1'b0);
        expect_word(32'h9100_0001, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_word(32'h9200_0001, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            step();
            if (ob_xfer) begin
                e = exp_q.pop_front();
                checks++;
                if (ob_dat !== e.dat || ob_eop !== e.eop || ob_owner !== e.owner || ob_busy !== e.busy) begin
                    failures++;
                    $display("FAIL rstmid_after got dat=%h eop=%b owner=%b busy=%b required %h %b %b %b",
                             ob_dat, ob_eop, ob_owner, ob_busy, e.dat, e.eop, e.owner, e.busy);
                end
            end
        end
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL rstmid_timeout pending=%0d required 0", exp_q.size());
        end
    endtask

    // Test sequence.
    initial begin
        reset = 1'b1; o_rdy = 1'b1; en1 = 1'b0; en2 = 1'b0; use_b = 1'b0;
        i1_dat = 32'h0; i1_val = 1'b0; i1_eop = 1'b0; i1_err = 1'b0;
        i2_dat = 32'h0; i2_val = 1'b0; i2_eop = 1'b0; i2_err = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_alternate();
        test_rdy_toggle();
        test_stall();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        test_maxlen(6, 1);
        test_maxlen(4, 0);
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
